hazard_stall_unit: RTL

- Consumes the ID-stage control bundle produced by the instruction decoder (RegWrite, MemRead, HI_LO_Write, Branch, Jump) together with the source and destination register fields.
- Tracks in-flight writers through the EX, MEM and WB stages in a small scoreboard.
- Generates stall and bubble signals for the 5-stage MIPS pipeline, plus a flush on taken branches and jumps.
- There is no forwarding: every read-after-write hazard on a still-in-flight destination stalls.

---
 rtl/pipeline_pkg.sv | 51 +++++
 rtl/hazard_stage_tracker.sv | 57 +++++
 rtl/hazard_stall_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage MIPS hazard logic: register index width,
// HI/LO write encodings, the in-flight writer scoreboard entry and helpers
// used to compare an ID-stage reader against one scoreboard entry.
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int REG_W = 5;

    // Decoder HI_LO_Write encodings.
    typedef enum logic [1:0] {
        HILO_NONE = 2'd0,
        HILO_HI   = 2'd1,
        HILO_LO   = 2'd2,
        HILO_BOTH = 2'd3
    } hilo_write_e;

    // One in-flight writer tracked through EX, MEM and WB.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             regwrite;
        logic [1:0]       hilowrite;
    } sb_entry_t;

    localparam sb_entry_t BUBBLE_ENTRY = '{
        valid:     1'b0,
        dest:      {REG_W{1'b0}},
        regwrite:  1'b0,
        hilowrite: 2'b00
    };

    // True when entry e will write a GPR that the ID instruction reads.
    // $0 is hard-wired to zero, so a write to it is never a dependency.
    function automatic logic reg_hit(input sb_entry_t        e,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             use_rs,
                                     input logic             use_rt);
        logic match_s;
        match_s = (use_rs && (rs == e.dest)) || (use_rt && (rt == e.dest));
        return e.valid && e.regwrite && (e.dest != {REG_W{1'b0}}) && match_s;
    endfunction

    // True when entry e will write HI and/or LO. Bubbles carry HILO_NONE.
    function automatic logic hilo_pending(input sb_entry_t e);
        return e.hilowrite != HILO_NONE;
    endfunction

endpackage

// File: rtl/hazard_stage_tracker.sv
// -----------------------------------------------------------------------------
// hazard_stage_tracker
// Three-deep shift register of in-flight writers (EX -> MEM -> WB). Each clock
// the ID entry enters EX, or a bubble does when bubble_i is set.
// Ports:
//   clk_i       pipeline clock
//   rst_i       synchronous active-high clear of all entries
//   bubble_i    load a bubble into EX instead of the ID entry
//   id_entry_i  writer description of the instruction leaving ID
//   ex_o/mem_o/wb_o  current scoreboard contents per stage
// -----------------------------------------------------------------------------
module hazard_stage_tracker
    import pipeline_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      bubble_i,
    input  sb_entry_t id_entry_i,
    output sb_entry_t ex_o,
    output sb_entry_t mem_o,
    output sb_entry_t wb_o
);

    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, mem_d;
    sb_entry_t wb_q, wb_d;

    // Next-state: shift one stage down, inserting a bubble into EX on request.
    always_comb begin
        ex_d  = BUBBLE_ENTRY;
        mem_d = ex_q;
        wb_d  = mem_q;
        if (bubble_i) begin
            ex_d = BUBBLE_ENTRY;
        end else begin
            ex_d = id_entry_i;
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q  <= BUBBLE_ENTRY;
            mem_q <= BUBBLE_ENTRY;
            wb_q  <= BUBBLE_ENTRY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Read-after-write hazard detection for a 5-stage MIPS pipeline with no
// forwarding. Any ID-stage read of a register (or HI/LO) still being produced
// in a checked stage stalls IF/ID and bubbles ID/EX. A taken branch/jump
// resolved in EX flushes IF/ID and overrides any stall.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   IDValid..IDHiLoWrite  ID-stage reader/writer description
//   EXRedirect            taken branch or jump resolved in EX
//   PCWrite, IFIDWrite    pipeline front-end enables (low while stalled)
//   IDEXBubble            zero the ID/EX control bundle
//   IFIDFlush             clear IF/ID to a nop
//   StallCount            saturating count of stalled cycles since reset
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int REG_W     = 5,
    parameter int CNT_W     = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IDValid,
    input  logic [REG_W-1:0] IDRs,
    input  logic [REG_W-1:0] IDRt,
    input  logic             IDUsesRs,
    input  logic             IDUsesRt,
    input  logic             IDReadsHiLo,
    input  logic [REG_W-1:0] IDDest,
    input  logic             IDRegWrite,
    input  logic             IDMemRead,
    input  logic [1:0]       IDHiLoWrite,
    input  logic             EXRedirect,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             IFIDFlush,
    output logic [CNT_W-1:0] StallCount
);

    import pipeline_pkg::sb_entry_t;
    import pipeline_pkg::reg_hit;
    import pipeline_pkg::hilo_pending;

    sb_entry_t  id_entry_s;
    sb_entry_t  ex_s, mem_s, wb_s;
    logic       tracker_bubble_s;
    logic       reg_haz_s;
    logic       hilo_haz_s;
    logic       stall_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Without forwarding a load and an ALU producer stall identically, so
    // MemRead carries no extra information here.
    logic unused_s;
    assign unused_s = IDMemRead;

    // Writer description of the ID instruction as it would enter EX.
    always_comb begin
        id_entry_s.valid     = 1'b1;
        id_entry_s.dest      = IDDest;
        id_entry_s.regwrite  = IDRegWrite;
        id_entry_s.hilowrite = IDHiLoWrite;
    end

    assign tracker_bubble_s = IDEXBubble | ~IDValid;

    hazard_stage_tracker u_tracker (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .bubble_i   (tracker_bubble_s),
        .id_entry_i (id_entry_s),
        .ex_o       (ex_s),
        .mem_o      (mem_s),
        .wb_o       (wb_s)
    );

    // Hazard detection; WB only matters when the register file cannot write
    // in the first half-cycle and be read in the second.
    always_comb begin
        reg_haz_s  = reg_hit(ex_s,  IDRs, IDRt, IDUsesRs, IDUsesRt)
                   | reg_hit(mem_s, IDRs, IDRt, IDUsesRs, IDUsesRt);
        hilo_haz_s = hilo_pending(ex_s) | hilo_pending(mem_s);
        if (WB_BYPASS == 1'b0) begin
            reg_haz_s  = reg_haz_s  | reg_hit(wb_s, IDRs, IDRt, IDUsesRs, IDUsesRt);
            hilo_haz_s = hilo_haz_s | hilo_pending(wb_s);
        end else begin
            reg_haz_s  = reg_haz_s;
            hilo_haz_s = hilo_haz_s;
        end
        hilo_haz_s = hilo_haz_s & IDReadsHiLo;
        // A redirect means ID holds a wrong-path instruction: never stall it.
        stall_s    = IDValid & (reg_haz_s | hilo_haz_s) & ~EXRedirect;
    end

    // Pipeline control outputs; reset holds the front end in a flushed state.
    always_comb begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b1;
        IFIDFlush  = 1'b1;
        if (Reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            IFIDFlush  = 1'b1;
        end else begin
            PCWrite    = ~stall_s;
            IFIDWrite  = ~stall_s;
            IDEXBubble = stall_s | EXRedirect;
            IFIDFlush  = EXRedirect;
        end
    end

    // Saturating stall counter next-state.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_s && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign StallCount = cnt_q;

endmodule
